// File: rtl/core_clk_ctrl.sv
// core_clk_ctrl: conditions the PLL clock into the pipeline clock and lock.
// Free-run division, single-step debug periods, delayed lock release and a
// pipeline cycle counter. All outputs are registered on I_CLOCK.
module core_clk_ctrl #(
    parameter int unsigned DIV_HALF   = 10000000,
    parameter int unsigned LOCK_DELAY = 4,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                 I_CLOCK,
    input  logic                 I_RESET_N,
    input  logic                 I_RUN,
    input  logic                 I_STEP,
    output logic                 O_CLK,
    output logic                 O_LOCK,
    output logic                 O_TICK,
    output logic [CNT_WIDTH-1:0] O_CYCLE
);

    // Phase counter terminal count and effective lock delay (0 behaves as 1).
    localparam logic [CNT_WIDTH-1:0] PHASE_TC = CNT_WIDTH'(DIV_HALF);
    localparam logic [7:0]           LOCK_TC  = (LOCK_DELAY == 0) ? 8'd1 : 8'(LOCK_DELAY);

    // Synchronizer reset values: bit 0 is run (idles high), bit 1 is step.
    localparam logic [1:0] SYNC_RST = 2'b01;

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_IDLE    = 2'd1,
        S_STEP_HI = 2'd2,
        S_STEP_LO = 2'd3
    } state_t;

    logic [1:0] async_in;
    logic [1:0] sync_bits;
    logic       run_s;
    logic       step_s;
    logic       step_s_d_reg;
    logic       step_pulse;

    state_t                 state_reg, state_next;
    logic [CNT_WIDTH-1:0]   phase_reg, phase_next;
    logic                   clk_reg, clk_next;
    logic                   tick_reg, tick_next;
    logic [7:0]             lock_cnt_reg, lock_cnt_next;
    logic                   lock_reg, lock_next;
    logic [CNT_WIDTH-1:0]   cycle_reg, cycle_next;
    logic                   toggle;
    logic                   rise;
    logic                   fall;

    assign async_in = {I_STEP, I_RUN};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;
            // Two-flop synchronizer for one asynchronous control level.
            always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
                if (!I_RESET_N) begin
                    meta_reg <= SYNC_RST[gi];
                    sync_reg <= SYNC_RST[gi];
                end else begin
                    meta_reg <= async_in[gi];
                    sync_reg <= meta_reg;
                end
            end
            assign sync_bits[gi] = sync_reg;
        end
    endgenerate

    assign run_s  = sync_bits[0];
    assign step_s = sync_bits[1];

    // Delayed copy of the synchronized step level for rising-edge detection.
    always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            step_s_d_reg <= 1'b0;
        end else begin
            step_s_d_reg <= step_s;
        end
    end

    assign step_pulse = step_s & ~step_s_d_reg;
    assign toggle     = (phase_reg == PHASE_TC);

    // Next-state logic: phase counting, clock toggling and run/step sequencing.
    always_comb begin
        state_next = state_reg;
        phase_next = (state_reg == S_IDLE) ? '0 :
                     (toggle ? '0 : phase_reg + CNT_WIDTH'(1));
        clk_next   = clk_reg;
        case (state_reg)
            S_RUN: begin
                if (toggle) begin
                    clk_next = ~clk_reg;
                    // Leave only at the end of a high phase so no phase is cut short.
                    if (clk_reg && !run_s) begin
                        state_next = S_IDLE;
                    end
                end
            end
            S_IDLE: begin
                clk_next = 1'b0;
                if (run_s) begin
                    // Run has priority over a coincident step request.
                    state_next = S_RUN;
                end else if (step_pulse) begin
                    clk_next   = 1'b1;
                    state_next = S_STEP_HI;
                end
            end
            S_STEP_HI: begin
                if (toggle) begin
                    clk_next   = 1'b0;
                    state_next = S_STEP_LO;
                end
            end
            S_STEP_LO: begin
                if (toggle) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                clk_next   = 1'b0;
                phase_next = '0;
                state_next = S_IDLE;
            end
        endcase
    end

    assign rise = ~clk_reg & clk_next;
    assign fall = clk_reg & ~clk_next;

    // Tick, lock qualification and cycle counting, all keyed off clock edges.
    always_comb begin
        tick_next     = rise;
        lock_cnt_next = lock_cnt_reg;
        lock_next     = lock_reg;
        cycle_next    = cycle_reg;
        if (rise && (lock_cnt_reg != LOCK_TC)) begin
            lock_cnt_next = lock_cnt_reg + 8'd1;
        end
        // Lock releases on a falling toggle so the pipeline sees it mid low phase.
        if (fall && (lock_cnt_reg == LOCK_TC)) begin
            lock_next = 1'b1;
        end
        if (rise && lock_reg) begin
            cycle_next = cycle_reg + CNT_WIDTH'(1);
        end
    end

    // State and output registers.
    always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            state_reg    <= S_RUN;
            phase_reg    <= '0;
            clk_reg      <= 1'b0;
            tick_reg     <= 1'b0;
            lock_cnt_reg <= 8'd0;
            lock_reg     <= 1'b0;
            cycle_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            phase_reg    <= phase_next;
            clk_reg      <= clk_next;
            tick_reg     <= tick_next;
            lock_cnt_reg <= lock_cnt_next;
            lock_reg     <= lock_next;
            cycle_reg    <= cycle_next;
        end
    end

    assign O_CLK   = clk_reg;
    assign O_LOCK  = lock_reg;
    assign O_TICK  = tick_reg;
    assign O_CYCLE = cycle_reg;

endmodule

// File: tb/tb_core_clk_ctrl.sv
// Testbench for core_clk_ctrl: two instances (slow divider with lock delay 2,
// and divide-by-one with a 4-bit wrapping cycle counter) checked every cycle
// against a waveform-level reference plus directed literal expectations.
module tb_core_clk_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn_a = 1'b0, run_a = 1'b1, step_a = 1'b0;
    logic rstn_b = 1'b0, run_b = 1'b1, step_b = 1'b0;

    logic        a_clk, a_lock, a_tick;
    logic [31:0] a_cyc;
    logic        b_clk, b_lock, b_tick;
    logic [3:0]  b_cyc;

    core_clk_ctrl #(.DIV_HALF(3), .LOCK_DELAY(2), .CNT_WIDTH(32)) u_dut_a (
        .I_CLOCK(clk), .I_RESET_N(rstn_a), .I_RUN(run_a), .I_STEP(step_a),
        .O_CLK(a_clk), .O_LOCK(a_lock), .O_TICK(a_tick), .O_CYCLE(a_cyc)
    );

    core_clk_ctrl #(.DIV_HALF(0), .LOCK_DELAY(0), .CNT_WIDTH(4)) u_dut_b (
        .I_CLOCK(clk), .I_RESET_N(rstn_b), .I_RUN(run_b), .I_STEP(step_b),
        .O_CLK(b_clk), .O_LOCK(b_lock), .O_TICK(b_tick), .O_CYCLE(b_cyc)
    );

    int n_vec = 0;
    int n_err = 0;
    bit b_done = 1'b0;

    // Reference model: mode 0 idle, 1 free run, 2 single step.
    int          m_mode [2];
    int          m_k    [2];
    int          m_rises[2];
    int          m_edge [2];
    bit          m_clk  [2];
    bit          m_tick [2];
    bit          m_lock [2];
    int unsigned m_cyc  [2];
    bit          run_h  [2][3];
    bit          step_h [2][3];

    function automatic int p_of(int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic int le_of(int i);
        return (i == 0) ? 2 : 1;
    endfunction

    function automatic int unsigned mask_of(int i);
        return (i == 0) ? 32'hFFFF_FFFF : 32'h0000_000F;
    endfunction

    task automatic model_reset(int i);
        m_mode[i] = 1; m_k[i] = 0; m_rises[i] = 0; m_edge[i] = 0;
        m_clk[i] = 0; m_tick[i] = 0; m_lock[i] = 0; m_cyc[i] = 0;
        for (int j = 0; j < 3; j++) begin
            run_h[i][j]  = 1'b1;
            step_h[i][j] = 1'b0;
        end
    endtask

    task automatic model_step(int i, bit run_in, bit step_in);
        bit run_s, pulse, prev, nxt;
        int p;
        p     = p_of(i);
        run_s = run_h[i][1];
        pulse = step_h[i][1] & ~step_h[i][2];
        run_h[i][2]  = run_h[i][1];  run_h[i][1]  = run_h[i][0];  run_h[i][0]  = run_in;
        step_h[i][2] = step_h[i][1]; step_h[i][1] = step_h[i][0]; step_h[i][0] = step_in;
        m_edge[i]++;
        prev = m_clk[i];
        nxt  = 1'b0;
        case (m_mode[i])
            1: begin
                m_k[i]++;
                nxt = ((m_k[i] / p) % 2) == 1;
                if (prev && !nxt && !run_s) m_mode[i] = 0;
            end
            2: begin
                m_k[i]++;
                nxt = (m_k[i] < p);
                if (m_k[i] == 2 * p) m_mode[i] = 0;
            end
            default: begin
                if (run_s) begin
                    m_mode[i] = 1; m_k[i] = 0;
                end else if (pulse) begin
                    m_mode[i] = 2; m_k[i] = 0; nxt = 1'b1;
                end
            end
        endcase
        m_tick[i] = !prev && nxt;
        if (!prev && nxt) begin
            if (m_lock[i]) m_cyc[i] = (m_cyc[i] + 1) & mask_of(i);
            if (m_rises[i] < le_of(i)) m_rises[i]++;
        end
        if (prev && !nxt && (m_rises[i] >= le_of(i))) m_lock[i] = 1'b1;
        m_clk[i] = nxt;
    endtask

    initial begin
        model_reset(0);
        forever begin
            @(posedge clk or negedge rstn_a);
            if (!rstn_a) model_reset(0);
            else         model_step(0, run_a, step_a);
        end
    end

    initial begin
        model_reset(1);
        forever begin
            @(posedge clk or negedge rstn_b);
            if (!rstn_b) model_reset(1);
            else         model_step(1, run_b, step_b);
        end
    end

    task automatic check(string name, int inst, logic [63:0] got, logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s inst=%0d t=%0t got=%0h exp=%0h", name, inst, $time, got, exp);
        end
    endtask

    // Wait until the given instance has seen `target` edges since reset release.
    task automatic wait_edge(int i, int target);
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (m_edge[i] < target && guard < 5000);
        if (m_edge[i] != target) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_edge inst=%0d got=%0d exp=%0d", i, m_edge[i], target);
        end
    endtask

    // Every-cycle comparison of both instances against the reference.
    initial begin
        forever begin
            @(negedge clk);
            check("clk",   0, a_clk,  m_clk[0]);
            check("lock",  0, a_lock, m_lock[0]);
            check("tick",  0, a_tick, m_tick[0]);
            check("cycle", 0, a_cyc,  m_cyc[0]);
            check("clk",   1, b_clk,  m_clk[1]);
            check("lock",  1, b_lock, m_lock[1]);
            check("tick",  1, b_tick, m_tick[1]);
            check("cycle", 1, b_cyc,  m_cyc[1]);
        end
    end

    // Instance B: divide-by-one, lock delay 0 (acts as 1), 4-bit wrap.
    initial begin
        wait_edge(1, 1);
        check("b_rise1_clk", 1, b_clk, 1); check("b_rise1_lock", 1, b_lock, 0);
        wait_edge(1, 2);
        check("b_lock_set", 1, b_lock, 1); check("b_fall_clk", 1, b_clk, 0);
        wait_edge(1, 3);
        check("b_cyc1", 1, b_cyc, 1); check("model_b_cyc1", 1, m_cyc[1], 1);
        wait_edge(1, 31);
        check("b_cyc15", 1, b_cyc, 15);
        wait_edge(1, 33);
        check("b_wrap0", 1, b_cyc, 0); check("b_wrap_tick", 1, b_tick, 1);
        b_done = 1'b1;
    end

    // Instance A: directed scenario sequence.
    initial begin
        int guard;
        repeat (3) @(negedge clk);
        check("rst_clk", 0, a_clk, 0); check("rst_lock", 0, a_lock, 0);
        check("rst_tick", 0, a_tick, 0); check("rst_cyc", 0, a_cyc, 0);
        rstn_a = 1'b1;
        rstn_b = 1'b1;

        // Free run: 4 low, 4 high, lock after the falling toggle of rise 2.
        wait_edge(0, 3);  check("a_low_first", 0, a_clk, 0);
        wait_edge(0, 4);  check("a_rise1", 0, a_clk, 1); check("a_tick1", 0, a_tick, 1);
        wait_edge(0, 5);  check("a_tick_1cyc", 0, a_tick, 0);
        wait_edge(0, 8);  check("a_fall1", 0, a_clk, 0);
        wait_edge(0, 15); check("a_nolock15", 0, a_lock, 0);
        wait_edge(0, 16); check("a_lock16", 0, a_lock, 1); check("model_a_lock", 0, m_lock[0], 1);
        wait_edge(0, 19); check("a_cyc0", 0, a_cyc, 0);
        wait_edge(0, 20); check("a_cyc1", 0, a_cyc, 1); check("model_a_cyc1", 0, m_cyc[0], 1);

        // Drop run inside the high phase: high completes, then idle.
        run_a = 1'b0;
        wait_edge(0, 23); check("a_high_kept", 0, a_clk, 1);
        wait_edge(0, 24); check("a_idle_fall", 0, a_clk, 0);
        wait_edge(0, 28); check("a_idle_norise", 0, a_clk, 0); check("a_idle_notick", 0, a_tick, 0);
        wait_edge(0, 36); check("a_idle_cyc", 0, a_cyc, 1);

        // Single step, with a second request during the period ignored.
        wait_edge(0, 40); step_a = 1'b1;
        wait_edge(0, 43); check("a_step_rise", 0, a_clk, 1); check("a_step_tick", 0, a_tick, 1);
        check("a_step_cyc", 0, a_cyc, 2); step_a = 1'b0;
        wait_edge(0, 45); step_a = 1'b1;
        wait_edge(0, 46); check("a_step_high4", 0, a_clk, 1);
        wait_edge(0, 47); check("a_step_fall", 0, a_clk, 0); step_a = 1'b0;
        wait_edge(0, 58); check("a_step_once", 0, a_clk, 0); check("a_step_once_cyc", 0, a_cyc, 2);

        // Run and step edge together: run wins, first rise 4 cycles later.
        wait_edge(0, 60); run_a = 1'b1; step_a = 1'b1;
        wait_edge(0, 62); step_a = 1'b0;
        wait_edge(0, 64); check("a_run_wins", 0, a_clk, 0);
        wait_edge(0, 66); check("a_run_low", 0, a_clk, 0);
        wait_edge(0, 67); check("a_run_rise", 0, a_clk, 1); check("a_run_cyc", 0, a_cyc, 3);

        // Asynchronous reset mid-high-phase with lock held.
        wait_edge(0, 68); check("a_pre_rst_lock", 0, a_lock, 1); check("a_pre_rst_clk", 0, a_clk, 1);
        #2 rstn_a = 1'b0;
        #1;
        check("a_arst_clk", 0, a_clk, 0); check("a_arst_lock", 0, a_lock, 0);
        check("a_arst_tick", 0, a_tick, 0); check("a_arst_cyc", 0, a_cyc, 0);
        @(negedge clk);
        rstn_a = 1'b1;
        wait_edge(0, 4);  check("a_re_rise1", 0, a_clk, 1); check("a_re_nolock", 0, a_lock, 0);
        wait_edge(0, 15); check("a_re_nolock15", 0, a_lock, 0);
        wait_edge(0, 16); check("a_re_lock16", 0, a_lock, 1);
        wait_edge(0, 20); check("a_re_cyc1", 0, a_cyc, 1);

        guard = 0;
        while (!b_done && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (!b_done) begin
            n_vec++;
            n_err++;
            $display("FAIL b_timeout got=%0d exp=%0d", b_done, 1);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/core_clk_ctrl.md
Name: core_clk_ctrl

Overview:
- Conditions the PLL output into the pipeline clock and pipeline lock that feed the Fetch/Decode/Execute/Memory/Writeback stages. Sits directly upstream of the pipeline top level and replaces the ad-hoc divider there.
- Provides free-run division, a single-step debug mode, a delayed lock release and a pipeline cycle counter.

Parameters:
- DIV_HALF, 10000000: terminal count of the phase counter. Each O_CLK phase lasts DIV_HALF+1 I_CLOCK cycles.
- LOCK_DELAY, 4: number of O_CLK rising edges after reset before O_LOCK asserts. Legal range 1..255; the value 0 is treated as 1.
- CNT_WIDTH, 32: width of the phase counter and of O_CYCLE.

Ports:
- I_CLOCK, in, 1: PLL c0 clock.
- I_RESET_N, in, 1: asynchronous active-low reset, driven from PLL locked.
- I_RUN, in, 1: asynchronous level. 1 selects free run; 0 selects single-step.
- I_STEP, in, 1: asynchronous step request, already debounced. The rising edge is the active event.
- O_CLK, out, 1: pipeline clock. Registered; never combinational.
- O_LOCK, out, 1: pipeline lock; drives the I_LOCK input of Fetch.
- O_TICK, out, 1: one-I_CLOCK-cycle pulse, registered in the same cycle that O_CLK goes 0 to 1.
- O_CYCLE, out, CNT_WIDTH: count of O_CLK rising edges since O_LOCK asserted.

Behaviour:
- Reset values: O_CLK=0, O_LOCK=0, O_TICK=0, O_CYCLE=0, phase counter=0, lock counter=0, state=S_RUN. Both synchronizers reset to run_s=1 and step_s=0.
- Input synchronization: I_RUN and I_STEP each pass through two flops. Step edge detect is step_s & ~step_s_d, a one-cycle pulse. Total input latency is 3 I_CLOCK cycles.
- Phase counter:
  - Counts only in S_RUN, S_STEP_HI and S_STEP_LO; it is held at 0 in S_IDLE.
  - When it equals DIV_HALF it returns to 0 and a toggle event fires (O_CLK inverts).
  - With DIV_HALF=0, O_CLK toggles every active cycle.
- States and transitions:
  - S_RUN: toggles continuously. If run_s=0 at a toggle event that takes O_CLK from 1 to 0, go to S_IDLE. The high phase is always completed; a low phase is never truncated.
  - S_IDLE: O_CLK held at 0. If run_s=1, go to S_RUN with counter=0. Otherwise a step pulse moves O_CLK to 1 and the state to S_STEP_HI. If both run_s=1 and a step pulse occur in the same cycle, run wins and the step is dropped.
  - S_STEP_HI: at the toggle event O_CLK goes to 0 and the state goes to S_STEP_LO.
  - S_STEP_LO: at the toggle event go to S_IDLE, with O_CLK staying 0.
  - Step pulses received in S_RUN, S_STEP_HI or S_STEP_LO are ignored, not queued.
  - Every step produces exactly one full O_CLK period: DIV_HALF+1 cycles high followed by DIV_HALF+1 cycles low.
- O_TICK is 1 in exactly the cycles where O_CLK is registered 0 to 1, in both run and step modes.
- Lock:
  - An 8-bit lock counter increments on each O_CLK rising edge, saturating at LOCK_DELAY.
  - O_LOCK is set on the first O_CLK 1-to-0 toggle after the counter reaches LOCK_DELAY, so it changes only in a low phase.
  - Once set, O_LOCK stays 1 until reset.
- O_CYCLE: increments by 1 on each O_TICK while O_LOCK=1, and wraps modulo 2^CNT_WIDTH.
- Reset mid-operation: all state and outputs clear immediately, asynchronously. After release, behaviour is identical to power-up, including the full LOCK_DELAY wait.

Test Plan:
- Parameters DIV_HALF=3, LOCK_DELAY=2, I_RUN=1, reset released -> O_CLK has an 8-cycle period, 4 cycles high and 4 low. O_TICK pulses every 8 cycles. O_LOCK rises on the falling toggle after the 2nd rising edge. O_CYCLE reads 1 after the next O_TICK.
- Drop I_RUN during an O_CLK high phase -> the high phase completes its 4 cycles, then O_CLK stays 0 and no further O_TICK occurs.
- In S_IDLE, a single I_STEP pulse -> exactly one period: 4 cycles high, 4 low. One O_TICK. O_CYCLE increments by 1. A second I_STEP during that period is ignored.
- In S_IDLE, I_RUN rising in the same cycle as a step edge -> free run resumes, with the first rising edge 4 cycles later and no extra step period.
- Assert I_RESET_N=0 mid-high-phase with O_LOCK=1 -> O_CLK, O_LOCK, O_TICK and O_CYCLE are 0 immediately. After release, O_LOCK returns only after 2 new rising edges.
- Parameters CNT_WIDTH=4, DIV_HALF=0 -> O_CLK toggles every cycle, and O_CYCLE wraps from 15 to 0 on the 16th tick after lock.
